// File: rtl/march_pkg.sv
// -----------------------------------------------------------------------------
// march_pkg
// Shared types and constants for the March C- sequencer:
//   state_e     - sequencer FSM states
//   elem_t      - one march element: direction, op count, per-op read flag and
//                 per-op data bit (bit i describes operation i of the element)
//   NUM_ELEM    - number of march elements (6)
//   elem_info   - element table lookup, index 0..5 (others return all-zero)
//   elem_is_down- direction lookup alone, for the next-element address preset
// -----------------------------------------------------------------------------
package march_pkg;

    localparam int NUM_ELEM = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic       down;     // 1: address runs WCOUNT-1 down to 0
        logic       two_ops;  // 1: element has two operations per address
        logic [1:0] op_rd;    // bit i: operation i is a read
        logic [1:0] op_one;   // bit i: operation i uses all-ones data
    } elem_t;

    // E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
    function automatic elem_t elem_info(input logic [2:0] idx);
        elem_t e;
        e = '0;
        case (idx)
            3'd0: e = '{down: 1'b0, two_ops: 1'b0, op_rd: 2'b00, op_one: 2'b00};
            3'd1: e = '{down: 1'b0, two_ops: 1'b1, op_rd: 2'b01, op_one: 2'b10};
            3'd2: e = '{down: 1'b0, two_ops: 1'b1, op_rd: 2'b01, op_one: 2'b01};
            3'd3: e = '{down: 1'b1, two_ops: 1'b1, op_rd: 2'b01, op_one: 2'b10};
            3'd4: e = '{down: 1'b1, two_ops: 1'b1, op_rd: 2'b01, op_one: 2'b01};
            3'd5: e = '{down: 1'b0, two_ops: 1'b0, op_rd: 2'b01, op_one: 2'b00};
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic elem_is_down(input logic [2:0] idx);
        elem_t e;
        e = elem_info(idx);
        return e.down;
    endfunction

endpackage

// File: rtl/march_rd_pipe.sv
// -----------------------------------------------------------------------------
// march_rd_pipe
// DEPTH-stage shift register that carries each outstanding read (valid,
// expected data, address, element) until the RAM returns its data.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - drop every in-flight entry (run aborted)
//   in_valid/exp/addr/elem   - entry loaded into stage 0
//   out_valid/exp/addr/elem  - entry leaving the last stage
// -----------------------------------------------------------------------------
module march_rd_pipe #(
    parameter int DEPTH   = 2,
    parameter int WLENGTH = 4,
    parameter int AW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WLENGTH-1:0] in_exp,
    input  logic [AW-1:0]      in_addr,
    input  logic [2:0]         in_elem,
    output logic               out_valid,
    output logic [WLENGTH-1:0] out_exp,
    output logic [AW-1:0]      out_addr,
    output logic [2:0]         out_elem
);

    logic [DEPTH-1:0]              vld_q;
    logic [DEPTH-1:0][WLENGTH-1:0] exp_q;
    logic [DEPTH-1:0][AW-1:0]      addr_q;
    logic [DEPTH-1:0][2:0]         elem_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q  <= '0;
            exp_q  <= '0;
            addr_q <= '0;
            elem_q <= '0;
        end else begin
            vld_q[0]  <= in_valid;
            exp_q[0]  <= in_exp;
            addr_q[0] <= in_addr;
            elem_q[0] <= in_elem;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
                elem_q[i] <= elem_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_exp   = exp_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign out_elem  = elem_q[DEPTH-1];

endmodule

// File: rtl/march_sequencer.sv
// -----------------------------------------------------------------------------
// march_sequencer
// March C- memory test sequencer. Issues one registered RAM operation per
// cycle, checks returned read data RD_LATENCY cycles later and reports a
// sticky fail flag.
// Optional build macro: MARCH_FAIL_CAPTURE_EN - when defined, fail_addr and
// fail_elem record the first mismatch of a run; otherwise they are tied to 0.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, abort      - run request (IDLE/DONE only), run termination
//   mem_addr/wdata/we/en, mem_rdata - RAM interface
//   busy, done, fail  - run status
//   fail_addr, fail_elem - first-mismatch location
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start, RAM interface quiet
// ST_RUN   | issuing operations; one extra cycle after the last one
// ST_DRAIN | waiting RD_LATENCY cycles for the last reads to return
// ST_DONE  | run complete, done held high until the next start
// -----------------------------------------------------------------------------
module march_sequencer
    import march_pkg::*;
#(
    parameter int WCOUNT     = 256,
    parameter int WLENGTH    = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic [$clog2(WCOUNT)-1:0] mem_addr,
    output logic [WLENGTH-1:0]        mem_wdata,
    output logic                      mem_we,
    output logic                      mem_en,
    input  logic [WLENGTH-1:0]        mem_rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [$clog2(WCOUNT)-1:0] fail_addr,
    output logic [2:0]                fail_elem
);

    localparam int             AW        = $clog2(WCOUNT);
    localparam logic [AW-1:0]  ADDR_LAST = AW'(WCOUNT - 1);
    localparam logic [AW-1:0]  ADDR_ONE  = AW'(1);

    state_e               state_q;
    logic [2:0]           elem_q;
    logic [AW-1:0]        addr_q;
    logic                 op_q;
    logic [2:0]           drain_q;
    logic [2:0]           op_elem_q;
    logic                 mem_en_q, mem_we_q;
    logic [AW-1:0]        mem_addr_q;
    logic [WLENGTH-1:0]   mem_wdata_q;
    logic                 busy_q, done_q, fail_q;

    elem_t                cur;
    logic                 last_op, last_addr;
    logic [AW-1:0]        addr_d;
    logic [2:0]           elem_d;
    logic                 op_d;
    logic                 run_start, run_abort, mismatch;

    logic                 pipe_vld;
    logic [WLENGTH-1:0]   pipe_exp;
    logic [AW-1:0]        pipe_addr;
    logic [2:0]           pipe_elem;

    // Cursor advance: finish all ops at this address, then step; at the end
    // of an element, preset the address for the next element's direction.
    always_comb begin
        cur       = elem_info(elem_q);
        last_op   = ~cur.two_ops | op_q;
        last_addr = cur.down ? (addr_q == '0) : (addr_q == ADDR_LAST);
        op_d      = ~last_op;
        elem_d    = elem_q;
        addr_d    = addr_q;
        if (last_op) begin
            if (last_addr) begin
                elem_d = elem_q + 3'd1;
                addr_d = elem_is_down(elem_q + 3'd1) ? ADDR_LAST : '0;
            end else begin
                addr_d = cur.down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
            end
        end
    end

    assign run_start = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign run_abort = abort && (state_q == ST_RUN || state_q == ST_DRAIN);
    assign mismatch  = pipe_vld && (mem_rdata != pipe_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            op_q        <= 1'b0;
            drain_q     <= '0;
            op_elem_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            if (mismatch) fail_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (run_start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        fail_q  <= 1'b0;
                        elem_q  <= '0;
                        addr_q  <= '0;
                        op_q    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end else if (elem_q == 3'(NUM_ELEM)) begin
                        state_q  <= ST_DRAIN;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        drain_q  <= 3'(RD_LATENCY - 1);
                    end else begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= ~cur.op_rd[op_q];
                        mem_addr_q  <= addr_q;
                        // reads carry their expected data here, then into the pipe
                        mem_wdata_q <= {WLENGTH{cur.op_one[op_q]}};
                        op_elem_q   <= elem_q;
                        addr_q      <= addr_d;
                        elem_q      <= elem_d;
                        op_q        <= op_d;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (drain_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Pipe is fed from the registered RAM outputs so its exit lines up with
    // the cycle in which mem_rdata is valid.
    march_rd_pipe #(
        .DEPTH   (RD_LATENCY),
        .WLENGTH (WLENGTH),
        .AW      (AW)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (run_abort),
        .in_valid  (mem_en_q & ~mem_we_q),
        .in_exp    (mem_wdata_q),
        .in_addr   (mem_addr_q),
        .in_elem   (op_elem_q),
        .out_valid (pipe_vld),
        .out_exp   (pipe_exp),
        .out_addr  (pipe_addr),
        .out_elem  (pipe_elem)
    );

`ifdef MARCH_FAIL_CAPTURE_EN
    logic [AW-1:0] fail_addr_q;
    logic [2:0]    fail_elem_q;

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else if (mismatch && !fail_q) begin
            fail_addr_q <= pipe_addr;
            fail_elem_q <= pipe_elem;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
`else
    logic unused_cap;
    assign unused_cap = ^{pipe_addr, pipe_elem};
    assign fail_addr  = '0;
    assign fail_elem  = '0;
`endif

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_march_sequencer.sv
// -----------------------------------------------------------------------------
// tb_march_sequencer
// Scoreboard bench for march_sequencer: a RAM model with an optional
// stuck-at bit, an operation list built from the March C- element table,
// and a monitor that pops one expected operation per mem_en cycle.
// Honours MARCH_FAIL_CAPTURE_EN for the fail_addr/fail_elem expectations.
// -----------------------------------------------------------------------------
module tb_march_sequencer;

    localparam int W    = 256;
    localparam int WL   = 4;
    localparam int RL   = 2;
    localparam int AW   = 8;
    localparam int NOPS = 10 * W;
`ifdef MARCH_FAIL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [WL-1:0] mem_wdata;
    logic          mem_we, mem_en;
    logic [WL-1:0] mem_rdata;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    march_sequencer #(.WCOUNT(W), .WLENGTH(WL), .RD_LATENCY(RL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_en    (mem_en),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- RAM model with optional stuck-at bit ----------------
    bit            f_en = 1'b0;
    int            f_addr = 0;
    int            f_bit = 0;
    bit            f_val = 1'b0;
    logic [WL-1:0] ram [W];
    logic [WL-1:0] rd_dly [RL];

    function automatic logic [WL-1:0] faulty(input int a, input logic [WL-1:0] d);
        logic [WL-1:0] r;
        r = d;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        rd_dly[0] <= faulty(int'(mem_addr), ram[mem_addr]);
        for (int i = 1; i < RL; i++) rd_dly[i] <= rd_dly[i-1];
    end
    assign mem_rdata = rd_dly[RL-1];

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [WL-1:0] data;
        int            elem;
    } op_t;

    op_t ops[$];
    op_t sb_q[$];

    // op codes: 0=w0 1=w1 2=r0 3=r1
    bit el_down [6] = '{0, 0, 0, 1, 1, 0};
    int el_nops [6] = '{1, 2, 2, 2, 2, 1};
    int el_op   [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};

    task automatic build_ops();
        op_t o;
        ops.delete();
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < W; i++)
                for (int k = 0; k < el_nops[e]; k++) begin
                    o.addr = AW'(el_down[e] ? (W - 1 - i) : i);
                    o.we   = (el_op[e][k] < 2);
                    o.data = (el_op[e][k] % 2 == 1) ? {WL{1'b1}} : {WL{1'b0}};
                    o.elem = e;
                    ops.push_back(o);
                end
    endtask

    task automatic model_fail(output bit ef, output int ea, output int ee);
        logic [WL-1:0] m [W];
        logic [WL-1:0] r;
        ef = 1'b0; ea = 0; ee = 0;
        foreach (ops[i]) begin
            if (ops[i].we) m[ops[i].addr] = ops[i].data;
            else begin
                r = faulty(int'(ops[i].addr), m[ops[i].addr]);
                if (!ef && r !== ops[i].data) begin
                    ef = 1'b1;
                    ea = int'(ops[i].addr);
                    ee = ops[i].elem;
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    int en_cnt = 0;

    always @(negedge clk) begin
        op_t           x;
        logic [WL-1:0] wd_act, wd_exp;
        if (mem_en) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: unexpected op addr 0x%0h we %0d, expected none", mem_addr, mem_we);
            end else begin
                x = sb_q.pop_front();
                wd_act = mem_we ? mem_wdata : {WL{1'b0}};
                wd_exp = x.we ? x.data : {WL{1'b0}};
                chk("mem_op", {mem_addr, mem_we, wd_act}, {x.addr, x.we, wd_exp});
            end
            if (en_cnt == 5 * W)
                chk("e3_first_op", {mem_addr, mem_we}, {AW'(W - 1), 1'b0});
            if (en_cnt == 5 * W + 1)
                chk("e3_second_op", {mem_addr, mem_we, mem_wdata}, {AW'(W - 1), 1'b1, {WL{1'b1}}});
            en_cnt++;
        end
    end

    // ---------------- one run ----------------
    // abort_off / rst_off / stray_off: edge index after the start edge at
    // which the pulse is sampled; 0 disables it.
    task automatic run(input bit fen, input int fa, input int fb, input bit fv,
                       input int abort_off, input int rst_off, input int stray_off);
        bit ef;
        int ea, ee, c_done, cut, issued;
        f_en = fen; f_addr = fa; f_bit = fb; f_val = fv;
        build_ops();
        model_fail(ef, ea, ee);
        if (!CAP) begin ea = 0; ee = 0; end
        foreach (ops[i]) sb_q.push_back(ops[i]);
        en_cnt = 0;
        c_done = -1;
        cut = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("post_start", {done, fail, busy, mem_en, fail_addr, fail_elem},
            {1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, 3'd0});
        for (int c = 1; c <= NOPS + RL + 20; c++) begin
            if (c == stray_off) start = 1'b1;
            if (c == abort_off) abort = 1'b1;
            if (c == rst_off)   rst   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            if (c == abort_off || c == rst_off) begin cut = c; break; end
            if (done) begin c_done = c; break; end
        end
        if (cut > 0) begin
            if (cut == rst_off)
                chk("reset_midrun_outputs",
                    {mem_addr, mem_wdata, mem_we, mem_en, busy, done, fail, fail_addr, fail_elem}, 64'd0);
            else
                chk("abort_outputs", {mem_en, mem_we, busy, done, fail}, 5'd0);
            issued = (cut - 1 < NOPS) ? cut - 1 : NOPS;
            chk("sb_left_after_stop", sb_q.size(), NOPS - issued);
            sb_q.delete();
            repeat (5) @(posedge clk);
            #1;
            chk("no_ops_after_stop", en_cnt, issued);
            chk("idle_after_stop", {busy, done, mem_en}, 3'd0);
        end else begin
            chk("done_latency", c_done, NOPS + RL + 1);
            chk("fail_flag", fail, ef);
            chk("fail_addr", fail_addr, ea);
            chk("fail_elem", fail_elem, ee);
            chk("mem_en_count", en_cnt, NOPS);
            chk("sb_drained", sb_q.size(), 0);
            chk("quiet_in_done", {busy, mem_en, mem_we}, 3'd0);
            @(posedge clk); #1;
            chk("done_held", {done, fail}, {1'b1, ef});
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {mem_addr, mem_wdata, mem_we, mem_en, busy, done, fail, fail_addr, fail_elem}, 64'd0);
        rst = 1'b0;

        run(1'b0, 0, 0, 1'b0, 0, 0, 777);             // fault-free, stray start mid-run
        run(1'b1, 'h35, 0, 1'b1, 0, 0, 1500);         // bit 0 stuck-at-1 at 0x35
        run(1'b0, 0, 0, 1'b0, 1000, 0, 0);            // abort at cycle 1000
        run(1'b0, 0, 0, 1'b0, 0, 0, 0);               // clean run after abort
        run(1'b0, 0, 0, 1'b0, 0, 500, 0);             // reset at cycle 500
        run(1'b0, 0, 0, 1'b0, 0, 0, 2000);            // clean run after reset
        for (int i = 0; i < 3; i++)
            run(1'b1, $urandom_range(0, W - 1), $urandom_range(0, WL - 1), 1'($urandom_range(0, 1)),
                0, 0, $urandom_range(2, NOPS));
        run(1'b0, 0, 0, 1'b0, $urandom_range(1, NOPS + RL), 0, 0);
        run(1'b1, $urandom_range(0, W - 1), $urandom_range(0, WL - 1), 1'($urandom_range(0, 1)), 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/march_sequencer.md
MARCH_SEQUENCER -- requirements
Module: march_sequencer

Interface
REQ-001 Parameter WCOUNT, default 256: number of RAM words; power of two, at least 8.
REQ-002 Parameter WLENGTH, default 4: RAM word width in bits.
REQ-003 Parameter RD_LATENCY, default 2: cycles from a read request on mem_* outputs to valid mem_rdata; range 1-7.
REQ-004 Port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: begin a March C- run; honoured in IDLE or DONE only.
REQ-007 Port abort, input, 1: terminate a run in progress.
REQ-008 Port mem_addr, output, clog2(WCOUNT): RAM address.
REQ-009 Port mem_wdata, output, WLENGTH: RAM write data.
REQ-010 Port mem_we, output, 1: write enable; 0 means read.
REQ-011 Port mem_en, output, 1: an operation is presented this cycle.
REQ-012 Port mem_rdata, input, WLENGTH: RAM read data.
REQ-013 Port busy, output, 1: run in progress, including drain.
REQ-014 Port done, output, 1: run complete; level, held in DONE.
REQ-015 Port fail, output, 1: sticky mismatch flag for the current run.
REQ-016 Port fail_addr, output, clog2(WCOUNT): address of the first mismatch.
REQ-017 Port fail_elem, output, 3: march element index (0-5) of the first mismatch.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 Elements, in order: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-020 Data 0 = all-zeros; data 1 = all-ones (WLENGTH bits).
REQ-021 All mem_* outputs registered; one operation per cycle with no gaps; each address finishes all operations of its element before the address steps.
REQ-022 Up elements run address 0 to WCOUNT-1; down elements run WCOUNT-1 to 0.
REQ-023 Total operations per run: 10*WCOUNT.
REQ-024 Start sampled at edge k in IDLE/DONE: first operation valid after edge k+1; fail, fail_addr, fail_elem and done clear at that edge.
REQ-025 After the last operation, enter DRAIN for RD_LATENCY cycles; done rises exactly 10*WCOUNT+RD_LATENCY+1 cycles after edge k.
REQ-026 Each read pushes {expected data, address, element} into a RD_LATENCY-deep pipe; on pipe exit, compare with mem_rdata.
REQ-027 On a mismatch, set fail on the next edge; it holds until the next start or reset.
REQ-028 Start while busy is ignored.
REQ-029 Abort in RUN or DRAIN: mem_en=0 on the next edge, pipe flushed, state returns to IDLE, done stays 0, fail is retained.
REQ-030 Start and abort in the same cycle: abort wins.
REQ-031 Outside RUN: mem_en=0, mem_we=0.

Reset
REQ-032 Reset sets state IDLE, clears the read pipe, and drives every output to 0.
REQ-033 Reset mid-run takes effect at the next edge; no mem_en after that edge.

Configuration
REQ-034 Macro MARCH_FAIL_CAPTURE_EN defined: fail_addr and fail_elem latch the first mismatch of a run and hold until the next start or reset.
REQ-035 Macro MARCH_FAIL_CAPTURE_EN undefined: fail_addr and fail_elem tied to 0, capture registers absent; fail behaviour unchanged.

Structure
REQ-036 Package march_pkg holds the FSM state enum, the element table (direction, op count, op data, read/write per op), and the constant NUM_ELEM=6.
REQ-037 Sub-module march_rd_pipe holds the RD_LATENCY-deep valid/expected/address/element shift register.

Verification
REQ-038 Fault-free RAM model, WCOUNT=256, RD_LATENCY=2, start pulse -> done at cycle 2563, fail=0, exactly 2560 mem_en cycles.
REQ-039 Bit 0 stuck-at-1 at address 0x35 -> fail=1, fail_addr=0x35, fail_elem=1, done still asserts at cycle 2563.
REQ-040 Check the first operation of E3 -> mem_addr=0xFF, mem_we=0; next cycle mem_we=1, mem_wdata=0xF.
REQ-041 Abort at cycle 1000 -> mem_en=0 from cycle 1001, state IDLE, done=0; a new start then completes cleanly.
REQ-042 Reset at cycle 500 mid-run -> all outputs 0 next cycle; a start pulse during RUN causes no restart.
